// File: rtl/mcp3008_pkg.sv
// Shared types, sizes and the conversion-result helper for the MCP3008 SPI responder.
// Pure declarations; no logic lives here.
package mcp3008_pkg;
    localparam int RESULT_W = 10;
    localparam int NUM_CH   = 8;
    localparam int CMD_BITS = 4;
    localparam int CHSEL_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        NULL_BIT,
        DATA,
        DONE
    } state_t;

    // Differential pairs are the even/odd neighbours; a negative difference reads as 0.
    function automatic logic [RESULT_W-1:0] calc_result(
        input logic [RESULT_W*NUM_CH-1:0] ch,
        input logic                       single,
        input logic [CHSEL_W-1:0]         sel
    );
        logic [RESULT_W-1:0] pos;
        logic [RESULT_W-1:0] neg;
        logic [RESULT_W:0]   diff;
        logic [CHSEL_W-1:0]  pair;
        pair = {sel[CHSEL_W-1:1], ~sel[0]};
        pos  = ch[int'(sel)*RESULT_W +: RESULT_W];
        neg  = ch[int'(pair)*RESULT_W +: RESULT_W];
        diff = {1'b0, pos} - {1'b0, neg};
        if (single)
            return pos;
        else if (diff[RESULT_W])
            return '0;
        else
            return diff[RESULT_W-1:0];
    endfunction
endpackage

// File: rtl/mcp3008_spi_responder_sync_edge.sv
// Synchronizer: STAGES-deep flop chain with rise/fall pulses from a one-clk-delayed copy.
// Latency STAGES clks to level, +0 to the edge pulses; no backpressure.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], sig};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/mcp3008_spi_responder.sv
// MCP3008-compatible SPI responder (mode 0,0): decodes start/SGL/D2..D0, returns a 10-bit result.
// Inputs cross SYNC_STAGES flops; spi_dout updates one clk after a detected sclk fall. No backpressure.
module mcp3008_spi_responder
    import mcp3008_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_cs_n,
    input  logic                       spi_clk,
    input  logic                       spi_din,
    output logic                       spi_dout,
    input  logic [RESULT_W*NUM_CH-1:0] ch_data,
    output logic                       cmd_valid,
    output logic                       cmd_single,
    output logic [CHSEL_W-1:0]         cmd_channel,
    output logic                       frame_error
);
    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic din_lvl, din_rise, din_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .sig(spi_cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .sig(spi_clk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst(rst), .sig(spi_din), .level(din_lvl), .rise(din_rise), .fall(din_fall));

    assign unused_edges = &{cs_rise, cs_fall, sclk_lvl, din_rise, din_fall};

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic [RESULT_W-1:0] shreg, shreg_nx;
    logic                dout_nx, cmd_valid_nx, cmd_single_nx, frame_error_nx;
    logic [CHSEL_W-1:0]  cmd_channel_nx;
    logic                armed, armed_nx;
    logic [2:0]          settle_cnt;
    logic                settled;

    // The cs_n synchronizer reads high out of reset regardless of the pin, so only
    // trust it as "master released cs" once the chain has flushed.
    assign settled = (settle_cnt == 3'(SYNC_STAGES));

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        shreg_nx       = shreg;
        dout_nx        = spi_dout;
        cmd_valid_nx   = 1'b0;
        cmd_single_nx  = cmd_single;
        cmd_channel_nx = cmd_channel;
        frame_error_nx = 1'b0;
        armed_nx       = armed | (settled & cs_lvl);

        if (cs_lvl) begin
            state_nx       = IDLE;
            cnt_nx         = '0;
            dout_nx        = 1'b0;
            frame_error_nx = state inside {CMD, NULL_BIT, DATA};
        end else begin
            case (state)
                IDLE: begin
                    if (armed)
                        state_nx = WAIT_START;
                end
                WAIT_START: begin
                    if (sclk_rise && din_lvl) begin
                        state_nx = CMD;
                        cnt_nx   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shreg_nx = {shreg[RESULT_W-2:0], din_lvl};
                        cnt_nx   = cnt + 4'd1;
                        if (cnt == 4'(CMD_BITS - 1)) begin
                            cmd_valid_nx   = 1'b1;
                            cmd_single_nx  = shreg[2];
                            cmd_channel_nx = {shreg[1:0], din_lvl};
                            state_nx       = NULL_BIT;
                        end
                    end
                end
                NULL_BIT: begin
                    if (sclk_fall) begin
                        shreg_nx = calc_result(ch_data, cmd_single, cmd_channel);
                        dout_nx  = 1'b0;
                        cnt_nx   = '0;
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        if (cnt == 4'(RESULT_W)) begin
                            dout_nx  = 1'b0;
                            state_nx = DONE;
                        end else begin
                            dout_nx  = shreg[RESULT_W-1];
                            shreg_nx = {shreg[RESULT_W-2:0], 1'b0};
                            cnt_nx   = cnt + 4'd1;
                        end
                    end
                end
                DONE:    dout_nx  = 1'b0;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            spi_dout    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_single  <= 1'b0;
            cmd_channel <= '0;
            frame_error <= 1'b0;
            armed       <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            shreg       <= shreg_nx;
            spi_dout    <= dout_nx;
            cmd_valid   <= cmd_valid_nx;
            cmd_single  <= cmd_single_nx;
            cmd_channel <= cmd_channel_nx;
            frame_error <= frame_error_nx;
            armed       <= armed_nx;
            if (!settled)
                settle_cnt <= settle_cnt + 3'd1;
        end
    end
endmodule
